// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register with a two-entry skid buffer.
// Registered ready/valid on both sides; flush discards everything held.
module ex_mem_skid #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [2:0]       in_wreg,
    input  logic             in_wen,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_wreg,
    output logic             out_wen,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] main_result, skid_result;
    logic [2:0]       main_wreg, skid_wreg;
    logic             main_wen, skid_wen;

    logic accept, emit;
    logic load_main_in, load_main_skid, load_skid;

    // Handshake outputs decode registered state only, so no comb path from in_valid/out_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_next   = ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid  = 1'b1;
                        state_next = FULL;
                    end else if (emit) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        load_main_skid = 1'b1;
                        state_next     = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // NOTE: the two buffer entries are reset so out_result/out_wreg read 0 straight after rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_result <= '0;
            main_wreg   <= '0;
            main_wen    <= 1'b0;
            skid_result <= '0;
            skid_wreg   <= '0;
            skid_wen    <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_result <= in_result;
                main_wreg   <= in_wreg;
                main_wen    <= in_wen;
            end else if (load_main_skid) begin
                main_result <= skid_result;
                main_wreg   <= skid_wreg;
                main_wen    <= skid_wen;
            end
            if (load_skid) begin
                skid_result <= in_result;
                skid_wreg   <= in_wreg;
                skid_wen    <= in_wen;
            end
        end
    end

    assign out_result = main_result;
    assign out_wreg   = main_wreg;
    assign out_wen    = main_wen & out_valid;
    assign count      = state;

endmodule
